// File: rtl/bin_to_bcd_pkg.sv
// Shared types for the binary-to-BCD converter: FSM state encoding and the BCD digit type.
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the following shift carries into the next decade.
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t result
);

    assign result = (digit >= 4'd5) ? bcd_digit_t'(digit + 4'd3) : digit;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter, one input bit per clock, MSB first.
// Defining BIN_TO_BCD_BLANK_EN adds a per-digit leading-zero mask output (blank).
module bin_to_bcd
    import bin_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
`ifdef BIN_TO_BCD_BLANK_EN
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
`else
    output logic [4*DIGITS-1:0]   bcd
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t                state;
    logic [WIDTH-1:0]      shreg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scratch_next;
    logic [WIDTH-1:0]      shreg_next;
    logic [CW-1:0]         cnt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3 u_add3 (
            .digit  (scratch[4*i +: 4]),
            .result (adj[4*i +: 4])
        );
    end

    // Correct first, then shift {scratch, shreg} left by one.
    assign scratch_next = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
    assign shreg_next   = {shreg[WIDTH-2:0], 1'b0};

`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_run;

    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (scratch_next[4*i +: 4] == 4'd0);
            blank_next[i] = zero_run;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
`ifdef BIN_TO_BCD_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    shreg   <= shreg_next;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= scratch_next;
`ifdef BIN_TO_BCD_BLANK_EN
                        blank <= blank_next;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd (WIDTH=8, DIGITS=3) against an arithmetic decimal reference.
module tb_bin_to_bcd;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [WIDTH-1:0]    bin_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0]   blank;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
`ifdef BIN_TO_BCD_BLANK_EN
        .bcd    (bcd),
        .blank  (blank)
`else
        .bcd    (bcd)
`endif
    );

    always #5 clk = ~clk;

    // Decimal digits by division, packed 4 bits per digit.
    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r = r | (32'((v / p) % 10) << (4 * d));
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i and everything above it are zero exactly when v < 10^i.
    function automatic logic [31:0] ref_blank(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            if (v < p) r[i] = 1'b1;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic convert(input int v);
        int k;
        @(negedge clk);
        start  = 1'b1;
        bin_in = WIDTH'(v);
        @(negedge clk);
        start  = 1'b0;
        check("busy_shift", 32'(busy), 32'd1);
        k = 0;
        while (!done && k < 40) begin
            bin_in = WIDTH'($urandom);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(WIDTH));
        check("bcd", 32'(bcd), ref_bcd(v));
`ifdef BIN_TO_BCD_BLANK_EN
        check("blank", 32'(blank), ref_blank(v));
`endif
        check("busy_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("bcd_hold", 32'(bcd), ref_bcd(v));
    endtask

    initial begin
        int k;
        int pulses;
        int t;
        int t0;
        int t1;

        reset  = 1'b1;
        start  = 1'b1;
        bin_in = 8'd77;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        start = 1'b0;
        reset = 1'b0;

        convert(0);
        convert(255);
        convert(99);
        convert(100);
        convert(7);

        // start and bin_in changes during SHIFT are ignored
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd42;
        @(negedge clk);
        bin_in = 8'd7;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("ign_latency", 32'(k), 32'(WIDTH));
        check("ign_bcd", 32'(bcd), 32'h042);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ign_extra_done", 32'(pulses), 32'd0);
        check("ign_bcd_hold", 32'(bcd), 32'h042);

        // held start gives back-to-back conversions
        @(negedge clk);
        start  = 1'b1;
        bin_in = 8'd123;
        t = 0; t0 = -1; t1 = -1;
        while (t1 < 0 && t < 60) begin
            @(negedge clk);
            t++;
            if (done) begin
                if (t0 < 0) t0 = t;
                else t1 = t;
            end
        end
        start = 1'b0;
        check("b2b_gap", 32'(t1 - t0), 32'(WIDTH + 2));
        check("b2b_bcd", 32'(bcd), 32'h123);
        repeat (4) @(negedge clk);

        // reset on the 4th SHIFT cycle abandons the conversion
        start  = 1'b1;
        bin_in = 8'd200;
        @(negedge clk);
        start  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);

        for (int v = 0; v < 256; v++) convert(v);
        repeat (40) convert(int'($urandom_range(255, 0)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning binary input width in bits (legal range 4..16).
REQ-002 SHALL have parameter DIGITS, default 3, meaning number of BCD output digits; DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning request conversion of bin_in; sampled only in IDLE.
REQ-006 SHALL have port bin_in  input  WIDTH  meaning unsigned binary value, captured on the start-accept edge.
REQ-007 SHALL have port busy  output  1  meaning conversion in progress, high in SHIFT.
REQ-008 SHALL have port done  output  1  meaning single-cycle pulse, high in DONE state only.
REQ-009 SHALL have port bcd  output  4*DIGITS  meaning packed BCD result, digit 0 in bits [3:0], for direct connection to per-digit 7-segment decoders.

Function
REQ-010 SHALL implement double-dabble (shift-add-3), one input bit per clock, MSB first.
REQ-011 SHALL use FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start=1; SHIFT->DONE after exactly WIDTH shift cycles; DONE->IDLE unconditionally.
REQ-012 SHALL, on start accept at edge N, load bin_in into a shift register and clear the BCD scratch register to zero in the same edge.
REQ-013 SHALL, in each SHIFT cycle, first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one.
REQ-014 SHALL assert done in the cycle after edge N+WIDTH (latency WIDTH+1 cycles from accept to done) and update bcd on that same edge.
REQ-015 SHALL hold bcd stable between completions; bcd changes only on the edge entering DONE.
REQ-016 SHALL ignore start while in SHIFT or DONE; bin_in changes after accept SHALL not affect the result.
REQ-017 SHALL accept a start held high continuously as back-to-back requests, one per WIDTH+2 cycles.
REQ-018 SHALL produce every digit in 0..9 for all inputs; no digit SHALL exceed 9.

Reset
REQ-019 SHALL, when reset=1 at a rising edge, enter IDLE and set busy=0, done=0, bcd=0, scratch and shift register=0, regardless of state.
REQ-020 SHALL, on reset mid-conversion, abandon the conversion with no done pulse; reset SHALL take priority over start.

Configuration
REQ-021 SHALL, when BIN_TO_BCD_BLANK_EN is defined, add output port blank  output  DIGITS  meaning per-digit leading-zero mask, updated with bcd, with blank[0] always 0.
REQ-022 SHALL, when BIN_TO_BCD_BLANK_EN is defined, set blank[i]=1 iff digit i and all higher digits are zero; reset value 0.
REQ-023 SHALL, when BIN_TO_BCD_BLANK_EN is undefined, have no blank port and no associated logic.

Structure
REQ-024 SHALL place the FSM state enum (IDLE, SHIFT, DONE) and a 4-bit bcd_digit_t typedef in shared package bin_to_bcd_pkg.
REQ-025 SHALL instantiate one combinational sub-module bcd_add3 per digit (input digit; output digit+3 if >=5, else unchanged).

Verification
REQ-026 SHALL cover: bin_in=8'd0, start pulse -> done after 9 cycles, bcd=12'h000.
REQ-027 SHALL cover: bin_in=8'd255 -> bcd=12'h255; bin_in=8'd99 -> bcd=12'h099; bin_in=8'd100 -> bcd=12'h100.
REQ-028 SHALL cover: start at accept with bin_in=8'd42, then start=1 and bin_in=8'd7 during SHIFT -> single done, bcd=12'h042.
REQ-029 SHALL cover: reset asserted on 4th SHIFT cycle of bin_in=8'd200 -> no done, bcd=0, busy=0 next cycle.
REQ-030 SHALL cover: exhaustive 0..255 against reference model; with BIN_TO_BCD_BLANK_EN, bin_in=8'd7 -> blank=3'b110, bin_in=8'd0 -> blank=3'b110.
